// File: rtl/multicycle_ctrl_if.sv
// Multicycle controller bus: opcode/flags in, datapath controls out.
// The controller sits on the slave side, and the instruction/datapath
// side (or a testbench) sits on the master side.
`timescale 1ns/1ps
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       memready;
    logic       pcen;
    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       illegal;
    logic [3:0] state;

    modport master (
        output op, zero, memready,
        input  pcen, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
               iord, memtoreg, regdst, alusrcb, pcsrc, aluop, illegal, state
    );

    modport slave (
        input  op, zero, memready,
        output pcen, pcwrite, memwrite, irwrite, regwrite, alusrca, branch,
               iord, memtoreg, regdst, alusrcb, pcsrc, aluop, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller (Moore FSM).
// The optional BNE support is enabled by defining MULTICYCLE_CTRL_BNE_EN.
// reset is asynchronous and active-low.
`timescale 1ns/1ps
module multicycle_ctrl (
    input  logic clk,
    input  logic reset,
    multicycle_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    state_t state_q;
    state_t state_d;
    logic   is_lw;
    logic   bne_q;
    logic   illegal_d;

    logic       pcwrite;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic       branch;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;

    // State register; reset drops straight back to FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Opcode class flags captured in DECODE and held for the rest of the instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 is_lw <= 1'b0;
        else if (state_q == DECODE) is_lw <= (bus.op == OP_LW);
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    // BNE flag inverts the zero sense of the branch condition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 bne_q <= 1'b0;
        else if (state_q == DECODE) bne_q <= (bus.op == OP_BNE);
    end
`else
    assign bne_q = 1'b0;
`endif

    // Next-state logic; unsupported opcodes flag illegal and abandon the instruction.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            FETCH:    if (bus.memready) state_d = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:       state_d = BRANCH;
`endif
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = is_lw ? MEMRD : MEMWR;
            MEMRD:    if (bus.memready) state_d = MEMWB;
            MEMWR:    if (bus.memready) state_d = FETCH;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    // Moore output decode from the state register (FETCH strobes qualified by memready).
    always_comb begin
        pcwrite  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (state_q)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = bus.memready;
                pcwrite = bus.memready;
            end
            DECODE:   alusrcb = 2'b11;
            MEMADR, ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD:    iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB:   regwrite = 1'b1;
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pcen     = pcwrite | (branch & (bus.zero ^ bne_q));
    assign bus.pcwrite  = pcwrite;
    assign bus.memwrite = memwrite;
    assign bus.irwrite  = irwrite;
    assign bus.regwrite = regwrite;
    assign bus.alusrca  = alusrca;
    assign bus.branch   = branch;
    assign bus.iord     = iord;
    assign bus.memtoreg = memtoreg;
    assign bus.regdst   = regdst;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.aluop    = aluop;
    assign bus.illegal  = illegal_d;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl with a per-cycle expectation queue.
// Honours MULTICYCLE_CTRL_BNE_EN for the op 000101 scenario.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    logic clk;
    logic reset;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [20:0] exp;
        string       tag;
    } entry_t;

    entry_t sb[$];
    int     errors = 0;
    int     checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector from the state/output table of the controller.
    function automatic logic [20:0] expVec(input logic [3:0] st, input logic mr,
                                           input logic z, input logic bq, input logic ill);
        logic pcw, mw, irw, rw, asa, br, iord, m2r, rd;
        logic [1:0] asb, pcs, aop;
        {pcw, mw, irw, rw, asa, br, iord, m2r, rd} = '0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            4'd0:       begin asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:       asb = 2'b11;
            4'd2, 4'd9: begin asa = 1'b1; asb = 2'b10; end
            4'd3:       iord = 1'b1;
            4'd4:       begin m2r = 1'b1; rw = 1'b1; end
            4'd5:       begin iord = 1'b1; mw = 1'b1; end
            4'd6:       begin asa = 1'b1; aop = 2'b10; end
            4'd7:       begin rd = 1'b1; rw = 1'b1; end
            4'd8:       begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; br = 1'b1; end
            4'd10:      rw = 1'b1;
            4'd11:      begin pcs = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        return {st, pcw | (br & (z ^ bq)), pcw, mw, irw, rw, asa, br, iord, m2r, rd,
                asb, pcs, aop, ill};
    endfunction

    function automatic logic [20:0] observed();
        return {bus.state, bus.pcen, bus.pcwrite, bus.memwrite, bus.irwrite, bus.regwrite,
                bus.alusrca, bus.branch, bus.iord, bus.memtoreg, bus.regdst,
                bus.alusrcb, bus.pcsrc, bus.aluop, bus.illegal};
    endfunction

    task automatic expectCycle(input string tag, input logic [5:0] opv, input logic z,
                               input logic mr, input logic [3:0] st, input logic bq,
                               input logic ill);
        entry_t e;
        e.op = opv; e.z = z; e.mr = mr; e.tag = tag;
        e.exp = expVec(st, mr, z, bq, ill);
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [5:0] opv, input logic z, input logic mr);
        bus.op       = opv;
        bus.zero     = z;
        bus.memready = mr;
    endtask

    task automatic checkOutput();
        entry_t e;
        logic [20:0] obs;
        e   = sb.pop_front();
        obs = observed();
        checks++;
        assert (obs === e.exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
        end
    endtask

    task automatic runQueue();
        while (sb.size() > 0) begin
            @(negedge clk);
            applyStimulus(sb[0].op, sb[0].z, sb[0].mr);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        applyStimulus(6'b000000, 1'b0, 1'b0);
        #1;
        expectCycle("reset_mr0", 6'b000000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(6'b000000, 1'b0, 1'b1);
        #1;
        expectCycle("reset_mr1", 6'b000000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        checkOutput();
        applyStimulus(6'b000000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // LW with memready high: 0,1,2,3,4
        expectCycle("lw_fetch_hold", 6'b100011, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expectCycle("lw_fetch",      6'b100011, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("lw_decode",     6'b100011, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("lw_memadr",     6'b100011, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        expectCycle("lw_memrd",      6'b100011, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
        expectCycle("lw_memwb",      6'b100011, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
        // SW with three wait cycles in MEMWR
        expectCycle("sw_fetch",      6'b101011, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("sw_decode",     6'b101011, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("sw_memadr",     6'b101011, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        expectCycle("sw_memwr_w1",   6'b101011, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        expectCycle("sw_memwr_w2",   6'b101011, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        expectCycle("sw_memwr_w3",   6'b101011, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0);
        expectCycle("sw_memwr_done", 6'b101011, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
        // R-type
        expectCycle("r_fetch",       6'b000000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("r_decode",      6'b000000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("r_execute",     6'b000000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
        expectCycle("r_aluwb",       6'b000000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        // ADDI
        expectCycle("addi_fetch",    6'b001000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("addi_decode",   6'b001000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("addi_exec",     6'b001000, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
        expectCycle("addi_wb",       6'b001000, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0);
        // BEQ taken and not taken
        expectCycle("beq1_fetch",    6'b000100, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("beq1_decode",   6'b000100, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("beq1_branch",   6'b000100, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
        expectCycle("beq0_fetch",    6'b000100, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("beq0_decode",   6'b000100, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("beq0_branch",   6'b000100, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
        // Jump
        expectCycle("j_fetch",       6'b000010, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("j_decode",      6'b000010, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("j_jump",        6'b000010, 1'b0, 1'b1, 4'd11, 1'b0, 1'b0);
        // Unsupported opcode
        expectCycle("ill_fetch",     6'b111111, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("ill_decode",    6'b111111, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
        expectCycle("ill_refetch",   6'b111111, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        // Op 000101: BNE when enabled, illegal otherwise
`ifdef MULTICYCLE_CTRL_BNE_EN
        expectCycle("bne0_fetch",    6'b000101, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("bne0_decode",   6'b000101, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("bne0_branch",   6'b000101, 1'b0, 1'b1, 4'd8, 1'b1, 1'b0);
        expectCycle("bne1_fetch",    6'b000101, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("bne1_decode",   6'b000101, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("bne1_branch",   6'b000101, 1'b1, 1'b1, 4'd8, 1'b1, 1'b0);
`else
        expectCycle("bne_fetch",     6'b000101, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("bne_decode",    6'b000101, 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
`endif
        // LW abandoned by reset while waiting in MEMRD
        expectCycle("rst_fetch",     6'b100011, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("rst_decode",    6'b100011, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("rst_memadr",    6'b100011, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0);
        expectCycle("rst_memrd",     6'b100011, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
        runQueue();

        #1 reset = 1'b0;
        #1;
        expectCycle("rst_async", 6'b100011, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput();
        @(negedge clk);
        #1;
        expectCycle("rst_held", 6'b100011, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        checkOutput();
        reset = 1'b1;

        expectCycle("post_fetch_w1", 6'b000000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expectCycle("post_fetch_w2", 6'b000000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        expectCycle("post_fetch",    6'b000000, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
        expectCycle("post_decode",   6'b000000, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        expectCycle("post_execute",  6'b000000, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
        expectCycle("post_aluwb",    6'b000000, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        expectCycle("post_refetch",  6'b000000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        runQueue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
